// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared memory-bus definitions for the core's memory path: address/data
// widths and the funct3 access-size codes (SEL_*), plus the grant-select
// encoding used inside the arbiter. The `define forms are the shared
// header values; the package re-exports them as typed localparams.
`ifndef MEM_ARBITER_DEFINES
`define MEM_ARBITER_DEFINES
`define ADDR_LEN 32
`define DATA_LEN 64
`define SEL_BYTE 3'b000
`define SEL_HALF 3'b001
`define SEL_WORD 3'b010
`define SEL_DWRD 3'b011
`define SEL_BYTU 3'b100
`define SEL_HLFU 3'b101
`define SEL_WRDU 3'b110
`endif

package mem_arbiter_pkg;

  localparam int ADDR_LEN = `ADDR_LEN;
  localparam int DATA_LEN = `DATA_LEN;

  localparam logic [2:0] SEL_BYTE = `SEL_BYTE;
  localparam logic [2:0] SEL_HALF = `SEL_HALF;
  localparam logic [2:0] SEL_WORD = `SEL_WORD;
  localparam logic [2:0] SEL_DWRD = `SEL_DWRD;
  localparam logic [2:0] SEL_BYTU = `SEL_BYTU;
  localparam logic [2:0] SEL_HLFU = `SEL_HLFU;
  localparam logic [2:0] SEL_WRDU = `SEL_WRDU;

  // Which port (if any) owns the memory this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P0   = 2'd1,
    GNT_P1   = 2'd2
  } gnt_sel_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port arbiter in front of a single-ported memory with combinational
// read and clocked write. Port 0 is instruction fetch (read-only), port 1 is
// load/store. Port 1 wins contention until it has won STARVE_MAX contended
// grants in a row, after which port 0 is forced through.
//
// Handshake: a requester holds pX_req and its fields stable until it sees
// pX_gnt=1 in the same cycle; dropping req before grant is a legal abort.
// A grant is a completed transfer: pX_rvalid pulses exactly one cycle later
// carrying the read data (or 0 for a store acknowledge on port 1).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   p0_req/addr/funct3    fetch request;  p0_gnt, p0_rvalid, p0_rdata response
//   p1_req/we/addr/funct3/wdata  load/store request; p1_gnt/rvalid/rdata
//   mem_wen (active low), mem_funct3, mem_waddr, mem_raddr, mem_wdata -> memory
//   mem_rdata             combinational read data from memory
//   dbg_starve_cnt        current starvation counter (observability)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  localparam int CNT_W = $clog2(STARVE_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_req,
  input  logic [`ADDR_LEN-1:0] p0_addr,
  input  logic [2:0]           p0_funct3,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [`DATA_LEN-1:0] p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [`ADDR_LEN-1:0] p1_addr,
  input  logic [2:0]           p1_funct3,
  input  logic [`DATA_LEN-1:0] p1_wdata,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [`DATA_LEN-1:0] p1_rdata,
  output logic                 mem_wen,
  output logic [2:0]           mem_funct3,
  output logic [`ADDR_LEN-1:0] mem_waddr,
  output logic [`ADDR_LEN-1:0] mem_raddr,
  output logic [`DATA_LEN-1:0] mem_wdata,
  input  logic [`DATA_LEN-1:0] mem_rdata,
  output logic [CNT_W-1:0]     dbg_starve_cnt
);

  localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]     r_starve_cnt;
  logic                 r_p0_rvalid;
  logic                 r_p1_rvalid;
  logic [`DATA_LEN-1:0] r_p0_rdata;
  logic [`DATA_LEN-1:0] r_p1_rdata;
  gnt_sel_e             w_sel;

  // Grant decision. Gated by rst_n so nothing is granted (and nothing is
  // written) while reset is held, independent of the request inputs.
  always_comb begin
    w_sel = GNT_NONE;
    if (rst_n) begin
      if (p1_req && (!p0_req || (r_starve_cnt < STARVE_MAX_C))) begin
        w_sel = GNT_P1;
      end else if (p0_req) begin
        w_sel = GNT_P0;
      end
    end
  end

  // Memory-side mux: idle cycles drive zeros and a deasserted write enable.
  always_comb begin
    mem_wen    = 1'b1;
    mem_funct3 = 3'b000;
    mem_waddr  = '0;
    mem_raddr  = '0;
    mem_wdata  = '0;
    case (w_sel)
      GNT_P0: begin
        mem_funct3 = p0_funct3;
        mem_waddr  = p0_addr;
        mem_raddr  = p0_addr;
      end
      GNT_P1: begin
        mem_funct3 = p1_funct3;
        mem_waddr  = p1_addr;
        mem_raddr  = p1_addr;
        if (p1_we) begin
          mem_wen   = 1'b0;
          mem_wdata = p1_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_p0_rvalid  <= 1'b0;
      r_p1_rvalid  <= 1'b0;
      r_p0_rdata   <= '0;
      r_p1_rdata   <= '0;
    end else begin
      // A p1 grant with p0_req high is necessarily a contended grant.
      if (!p0_req || (w_sel == GNT_P0)) begin
        r_starve_cnt <= '0;
      end else if ((w_sel == GNT_P1) && (r_starve_cnt < STARVE_MAX_C)) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end

      r_p0_rvalid <= (w_sel == GNT_P0);
      r_p1_rvalid <= (w_sel == GNT_P1);
      if (w_sel == GNT_P0) begin
        r_p0_rdata <= mem_rdata;
      end
      if (w_sel == GNT_P1) begin
        r_p1_rdata <= p1_we ? '0 : mem_rdata;
      end
    end
  end

  assign p0_gnt         = (w_sel == GNT_P0);
  assign p1_gnt         = (w_sel == GNT_P1);
  assign p0_rvalid      = r_p0_rvalid;
  assign p1_rvalid      = r_p1_rvalid;
  assign p0_rdata       = r_p0_rdata;
  assign p1_rdata       = r_p1_rdata;
  assign dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                p0_req, p1_req, p1_we;
  logic [ADDR_LEN-1:0] p0_addr, p1_addr;
  logic [2:0]          p0_funct3, p1_funct3;
  logic [DATA_LEN-1:0] p1_wdata;
  logic                p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DATA_LEN-1:0] p0_rdata, p1_rdata;
  logic                mem_wen;
  logic [2:0]          mem_funct3;
  logic [ADDR_LEN-1:0] mem_waddr, mem_raddr;
  logic [DATA_LEN-1:0] mem_wdata, mem_rdata;
  logic [2:0]          dbg_starve_cnt;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_funct3(p0_funct3),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_funct3(p1_funct3),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_wen(mem_wen), .mem_funct3(mem_funct3), .mem_waddr(mem_waddr),
    .mem_raddr(mem_raddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- memory model ----------------
  // Combinational read, clocked write: a store followed by a load on the
  // next cycle sees the new data without any help from the arbiter.
  logic [63:0] mem_arr [0:31];

  function automatic logic [63:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] mem_read(input logic [63:0] word, input logic [2:0] off,
                                           input logic [2:0] f3);
    logic [63:0] v;
    v = (word >> {off, 3'b000}) & size_mask(f3);
    case (f3)
      SEL_BYTE: v = {{56{v[7]}}, v[7:0]};
      SEL_HALF: v = {{48{v[15]}}, v[15:0]};
      SEL_WORD: v = {{32{v[31]}}, v[31:0]};
      default:  ;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] mem_merge(input logic [63:0] old, input logic [63:0] data,
                                            input logic [2:0] off, input logic [2:0] f3);
    logic [63:0] m;
    m = size_mask(f3) << {off, 3'b000};
    return (old & ~m) | ((data << {off, 3'b000}) & m);
  endfunction

  assign mem_rdata = mem_read(mem_arr[mem_raddr[7:3]], mem_raddr[2:0], mem_funct3);

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= 64'h0;
      mem_arr[2] <= 64'h1122_3344_5566_7788;  // addr 0x10
      mem_arr[4] <= 64'hAAAA_AAAA_5555_5555;  // addr 0x20
    end else if (!mem_wen) begin
      mem_arr[mem_waddr[7:3]] <= mem_merge(mem_arr[mem_waddr[7:3]], mem_wdata,
                                           mem_waddr[2:0], mem_funct3);
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    p0_req = 1'b0; p0_addr = '0; p0_funct3 = 3'b0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_funct3 = 3'b0; p1_wdata = '0;
  endtask

  task automatic drive_p0(input logic [31:0] addr, input logic [2:0] f3);
    p0_req = 1'b1; p0_addr = addr; p0_funct3 = f3;
  endtask

  task automatic drive_p1(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [63:0] wdata);
    p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_funct3 = f3; p1_wdata = wdata;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    drive_idle();
    // Reset held with both ports requesting and a store pending.
    drive_p0(32'h10, SEL_DWRD);
    drive_p1(1'b1, 32'h20, SEL_DWRD, 64'h1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_p0_gnt", p0_gnt, 0);
    check_eq("rst_p1_gnt", p1_gnt, 0);
    check_eq("rst_mem_wen", mem_wen, 1);
    check_eq("rst_p0_rvalid", p0_rvalid, 0);
    check_eq("rst_p1_rvalid", p1_rvalid, 0);
    check_eq("rst_p0_rdata", p0_rdata, 0);
    check_eq("rst_p1_rdata", p1_rdata, 0);
    check_eq("rst_starve", dbg_starve_cnt, 0);
    drive_idle();
    rst_n = 1'b1;
    next_cycle();

    // Solo read on port 0.
    drive_p0(32'h10, SEL_DWRD);
    #1;
    check_eq("solo_p0_gnt", p0_gnt, 1);
    check_eq("solo_p1_gnt", p1_gnt, 0);
    check_eq("solo_raddr", mem_raddr, 32'h10);
    check_eq("solo_funct3", mem_funct3, SEL_DWRD);
    check_eq("solo_wen", mem_wen, 1);
    next_cycle();
    drive_idle();
    #1;
    check_eq("solo_rvalid", p0_rvalid, 1);
    check_eq("solo_rdata", p0_rdata, 64'h1122_3344_5566_7788);
    check_eq("solo_p1_rvalid", p1_rvalid, 0);
    next_cycle();
    check_eq("solo_rvalid_pulse", p0_rvalid, 0);
    check_eq("solo_rdata_hold", p0_rdata, 64'h1122_3344_5566_7788);

    // Store word then load word-unsigned from the same address.
    drive_p1(1'b1, 32'h20, SEL_WORD, 64'hFFFF_FFFF_DEAD_BEEF);
    #1;
    check_eq("st_p1_gnt", p1_gnt, 1);
    check_eq("st_wen", mem_wen, 0);
    check_eq("st_waddr", mem_waddr, 32'h20);
    check_eq("st_wdata", mem_wdata, 64'hFFFF_FFFF_DEAD_BEEF);
    next_cycle();
    drive_p1(1'b0, 32'h20, SEL_WRDU, 64'h0);
    #1;
    check_eq("ld_p1_gnt", p1_gnt, 1);
    check_eq("ld_wen", mem_wen, 1);
    check_eq("ld_wdata_zero", mem_wdata, 0);
    check_eq("st_ack_rvalid", p1_rvalid, 1);
    check_eq("st_ack_rdata", p1_rdata, 0);
    next_cycle();
    drive_idle();
    #1;
    check_eq("ld_rvalid", p1_rvalid, 1);
    check_eq("ld_rdata", p1_rdata, 64'h0000_0000_DEAD_BEEF);
    next_cycle();
    check_eq("ld_rvalid_pulse", p1_rvalid, 0);

    // Contention: both request every cycle; p0 is forced after four p1 wins.
    drive_p0(32'h10, SEL_DWRD);
    drive_p1(1'b0, 32'h20, SEL_DWRD, 64'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq($sformatf("cont_p1_gnt_%0d", i), p1_gnt, ((i % 5) != 4) ? 1 : 0);
      check_eq($sformatf("cont_p0_gnt_%0d", i), p0_gnt, ((i % 5) == 4) ? 1 : 0);
      check_eq($sformatf("cont_starve_%0d", i), dbg_starve_cnt, i % 5);
      next_cycle();
    end

    // Idle: nothing granted, memory quiet, responses held.
    drive_idle();
    #1;
    check_eq("idle_p0_gnt", p0_gnt, 0);
    check_eq("idle_p1_gnt", p1_gnt, 0);
    check_eq("idle_wen", mem_wen, 1);
    check_eq("idle_raddr", mem_raddr, 0);
    check_eq("idle_funct3", mem_funct3, 0);
    next_cycle();
    check_eq("idle_p0_rvalid", p0_rvalid, 0);
    check_eq("idle_p1_rvalid", p1_rvalid, 0);
    check_eq("idle_p0_rdata", p0_rdata, 64'h1122_3344_5566_7788);
    check_eq("idle_p1_rdata", p1_rdata, 64'hAAAA_AAAA_DEAD_BEEF);

    // Abort: p0 loses to p1, then withdraws before being granted.
    drive_p0(32'h10, SEL_DWRD);
    drive_p1(1'b0, 32'h20, SEL_DWRD, 64'h0);
    #1;
    check_eq("abort_p1_gnt", p1_gnt, 1);
    check_eq("abort_p0_gnt", p0_gnt, 0);
    next_cycle();
    drive_idle();
    #1;
    check_eq("abort_p0_gnt2", p0_gnt, 0);
    check_eq("abort_p1_rvalid", p1_rvalid, 1);
    next_cycle();
    check_eq("abort_p0_rvalid", p0_rvalid, 0);

    // Reset asserted mid-way through a contended p1 store grant.
    drive_p0(32'h10, SEL_DWRD);
    drive_p1(1'b1, 32'h28, SEL_DWRD, 64'h5);
    next_cycle();
    #1;
    check_eq("mr_p1_gnt", p1_gnt, 1);
    check_eq("mr_wen_pre", mem_wen, 0);
    check_eq("mr_starve_pre", dbg_starve_cnt, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_wen_rst", mem_wen, 1);
    check_eq("mr_p1_gnt_rst", p1_gnt, 0);
    check_eq("mr_starve_rst", dbg_starve_cnt, 0);
    next_cycle();
    drive_idle();
    rst_n = 1'b1;
    next_cycle();
    check_eq("mr_p0_rvalid", p0_rvalid, 0);
    check_eq("mr_p1_rvalid", p1_rvalid, 0);
    check_eq("mr_starve_post", dbg_starve_cnt, 0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
